// File: rtl/pack_phrase_if.sv
// Word-in / phrase-out stream bundle for pack_phrase.
// master is the side that sources words and sinks phrases; slave is the packer.
interface pack_phrase_if;
  logic         valid_word;
  logic         ready_word;
  logic [15:0]  word;
  logic         word_last;
  logic         valid_phrase;
  logic         ready_phrase;
  logic [127:0] phrase_data;
  logic         phrase_last;
  logic [3:0]   phrase_count;

  modport master (
    output valid_word, word, word_last, ready_phrase,
    input  ready_word, valid_phrase, phrase_data, phrase_last, phrase_count
  );

  modport slave (
    input  valid_word, word, word_last, ready_phrase,
    output ready_word, valid_phrase, phrase_data, phrase_last, phrase_count
  );
endinterface

// File: rtl/pack_phrase.sv
// Packs 16-bit words into 128-bit phrases (word 0 in [15:0]); an end-of-frame word
// forces out a padded partial phrase so frames always start on a phrase boundary.
module pack_phrase #(
  parameter logic [15:0] PAD_WORD = 16'h0000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  pack_phrase_if.slave bus
);

  typedef enum logic {StFill, StFlush} state_t;

  state_t       r_state;
  logic [127:0] r_acc;
  logic [2:0]   r_cnt;
  logic [127:0] r_data;
  logic [3:0]   r_count;
  logic         r_last;
  logic         r_valid;

  logic         w_out_free;
  logic         w_ready_word;
  logic         w_accept;
  logic [3:0]   w_keep;
  logic [127:0] w_phrase;

  assign w_out_free   = !r_valid || bus.ready_phrase;
  assign w_ready_word = (r_state == StFill) && (w_out_free || (r_cnt != 3'd7));
  assign w_accept     = bus.valid_word && w_ready_word;

  // In FILL the incoming word is a real lane; in FLUSH only the stored lanes count.
  assign w_keep = (r_state == StFill) ? ({1'b0, r_cnt} + 4'd1) : {1'b0, r_cnt};

  always_comb begin
    w_phrase = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) >= w_keep) begin
        w_phrase[i*16 +: 16] = PAD_WORD;
      end else if (3'(i) == r_cnt) begin
        w_phrase[i*16 +: 16] = bus.word;
      end else begin
        w_phrase[i*16 +: 16] = r_acc[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= StFill;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      // A load below overrides this, giving back-to-back phrases without a bubble.
      if (r_valid && bus.ready_phrase) r_valid <= 1'b0;
      unique case (r_state)
        StFill: begin
          if (w_accept) begin
            if ((r_cnt == 3'd7) || (bus.word_last && w_out_free)) begin
              r_data  <= w_phrase;
              r_count <= w_keep;
              r_last  <= bus.word_last;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_acc   <= '0;
            end else begin
              r_acc[{r_cnt, 4'b0000} +: 16] <= bus.word;
              r_cnt <= r_cnt + 3'd1;
              if (bus.word_last) r_state <= StFlush;
            end
          end
        end
        StFlush: begin
          if (w_out_free) begin
            r_data  <= w_phrase;
            r_count <= w_keep;
            r_last  <= 1'b1;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= StFill;
          end
        end
      endcase
    end
  end

  assign bus.ready_word   = w_ready_word;
  assign bus.valid_phrase = r_valid;
  assign bus.phrase_data  = r_data;
  assign bus.phrase_last  = r_last;
  assign bus.phrase_count = r_count;

endmodule

// File: tb/tb_pack_phrase.sv
// Directed bench for pack_phrase: full phrases, streaming, stalls, padded flushes, reset.
module tb_pack_phrase;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   vcycles;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   count;
    logic         last;
    int           cyc;
  } rec_t;

  rec_t q[$];

  pack_phrase_if bus();

  pack_phrase #(.PAD_WORD(16'hFFFF)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_phrase) vcycles++;
      if (bus.valid_phrase && bus.ready_phrase)
        q.push_back('{bus.phrase_data, bus.phrase_count, bus.phrase_last, cyc});
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] seq_phrase(input logic [15:0] base);
    logic [127:0] p;
    for (int j = 0; j < 8; j++) p[j*16 +: 16] = base + 16'(j);
    return p;
  endfunction

  int stalls;

  // Presents one word and holds it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_word(input logic [15:0] w, input logic last);
    int n;
    bus.valid_word = 1'b1;
    bus.word       = w;
    bus.word_last  = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_word) break;
      n++;
      if (n > 100) begin
        check_eq("send_timeout", 128'(bus.ready_word), 128'd1);
        break;
      end
    end
    if (n != 0) stalls++;
    @(posedge clk);
    #1;
    bus.valid_word = 1'b0;
    bus.word_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    vcycles = 0;
    stalls  = 0;
  endtask

  task automatic check_rec(input string tag, input int k, input logic [127:0] data,
                           input logic [3:0] count, input logic last);
    if (k < q.size()) begin
      check_eq({tag, "_data"}, q[k].data, data);
      check_eq({tag, "_count"}, 128'(q[k].count), 128'(count));
      check_eq({tag, "_last"}, 128'(q[k].last), 128'(last));
    end else begin
      check_eq({tag, "_present"}, 128'(q.size()), 128'(k + 1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vcycles = 0;
    stalls = 0;
    rst_n = 1'b0;
    bus.valid_word = 1'b0;
    bus.word = '0;
    bus.word_last = 1'b0;
    bus.ready_phrase = 1'b0;
    #12;
    check_eq("rst_valid", 128'(bus.valid_phrase), 128'd0);
    check_eq("rst_data", bus.phrase_data, 128'd0);
    check_eq("rst_count", 128'(bus.phrase_count), 128'd0);
    check_eq("rst_last", 128'(bus.phrase_last), 128'd0);
    check_eq("rst_ready_word", 128'(bus.ready_word), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // 1: eight words make one full phrase, valid the cycle after word 8
    bus.ready_phrase = 1'b1;
    for (int i = 1; i <= 8; i++) send_word(16'(i), 1'b0);
    check_eq("t1_valid", 128'(bus.valid_phrase), 128'd1);
    check_eq("t1_data", bus.phrase_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check_eq("t1_count", 128'(bus.phrase_count), 128'd8);
    check_eq("t1_last", 128'(bus.phrase_last), 128'd0);
    idle(1);

    // 2: 24 words streamed at full rate
    clear_mon();
    for (int i = 0; i < 24; i++) send_word(16'h0101 + 16'(i), 1'b0);
    idle(2);
    check_eq("t2_stalls", 128'(stalls), 128'd0);
    check_eq("t2_nphrases", 128'(q.size()), 128'd3);
    check_eq("t2_valid_cycles", 128'(vcycles), 128'd3);
    for (int k = 0; k < 3; k++) check_rec("t2_ph", k, seq_phrase(16'h0101 + 16'(8 * k)), 4'd8, 1'b0);
    if (q.size() == 3) begin
      check_eq("t2_gap01", 128'(q[1].cyc - q[0].cyc), 128'd8);
      check_eq("t2_gap12", 128'(q[2].cyc - q[1].cyc), 128'd8);
    end

    // 3: downstream stall after first phrase
    clear_mon();
    for (int i = 0; i < 8; i++) send_word(16'h0201 + 16'(i), 1'b0);
    bus.ready_phrase = 1'b0;
    for (int i = 8; i < 15; i++) send_word(16'h0201 + 16'(i), 1'b0);
    bus.valid_word = 1'b1;
    bus.word = 16'h0210;
    @(negedge clk);
    check_eq("t3_ready_drop", 128'(bus.ready_word), 128'd0);
    @(negedge clk);
    check_eq("t3_hold_data", bus.phrase_data, seq_phrase(16'h0201));
    check_eq("t3_hold_valid", 128'(bus.valid_phrase), 128'd1);
    check_eq("t3_hold_count", 128'(bus.phrase_count), 128'd8);
    @(posedge clk);
    #1;
    bus.ready_phrase = 1'b1;
    send_word(16'h0210, 1'b0);
    check_eq("t3_p2_data", bus.phrase_data, seq_phrase(16'h0209));
    idle(2);
    check_eq("t3_nphrases", 128'(q.size()), 128'd2);
    check_rec("t3_p1", 0, seq_phrase(16'h0201), 4'd8, 1'b0);
    check_rec("t3_p2", 1, seq_phrase(16'h0209), 4'd8, 1'b0);

    // 4: short frame padded with PAD_WORD
    clear_mon();
    send_word(16'hDEAD, 1'b0);
    send_word(16'hDEAD, 1'b0);
    send_word(16'hDEAD, 1'b1);
    check_eq("t4_data", bus.phrase_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_DEAD_DEAD_DEAD);
    check_eq("t4_count", 128'(bus.phrase_count), 128'd3);
    check_eq("t4_last", 128'(bus.phrase_last), 128'd1);
    idle(2);
    check_eq("t4_nphrases", 128'(q.size()), 128'd1);

    // 5: frame end while output stalled goes through FLUSH
    clear_mon();
    for (int i = 0; i < 8; i++) send_word(16'h0501 + 16'(i), 1'b0);
    bus.ready_phrase = 1'b0;
    send_word(16'h0511, 1'b0);
    send_word(16'h0512, 1'b1);
    check_eq("t5_flush_ready0", 128'(bus.ready_word), 128'd0);
    @(negedge clk);
    check_eq("t5_flush_ready1", 128'(bus.ready_word), 128'd0);
    check_eq("t5_hold_data", bus.phrase_data, seq_phrase(16'h0501));
    @(posedge clk);
    #1;
    bus.ready_phrase = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_f_data", bus.phrase_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0512_0511);
    check_eq("t5_f_count", 128'(bus.phrase_count), 128'd2);
    check_eq("t5_f_last", 128'(bus.phrase_last), 128'd1);
    check_eq("t5_ready_back", 128'(bus.ready_word), 128'd1);
    for (int i = 0; i < 8; i++) send_word(16'h0521 + 16'(i), 1'b0);
    idle(2);
    check_eq("t5_nphrases", 128'(q.size()), 128'd3);
    check_rec("t5_a", 0, seq_phrase(16'h0501), 4'd8, 1'b0);
    check_rec("t5_f", 1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0512_0511, 4'd2, 1'b1);
    check_rec("t5_c", 2, seq_phrase(16'h0521), 4'd8, 1'b0);

    // 6: asynchronous reset mid-phrase discards partial data
    for (int i = 0; i < 5; i++) send_word(16'h0601 + 16'(i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 128'(bus.valid_phrase), 128'd0);
    check_eq("t6_rst_data", bus.phrase_data, 128'd0);
    check_eq("t6_rst_count", 128'(bus.phrase_count), 128'd0);
    check_eq("t6_rst_last", 128'(bus.phrase_last), 128'd0);
    check_eq("t6_rst_ready", 128'(bus.ready_word), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    clear_mon();
    for (int i = 0; i < 8; i++) send_word(16'h0701 + 16'(i), 1'b0);
    idle(2);
    check_eq("t6_nphrases", 128'(q.size()), 128'd1);
    check_rec("t6_ph", 0, seq_phrase(16'h0701), 4'd8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
